mlblock_tile_sequencer: RTL and testbench



---
 rtl/mlblock_seq_pkg.sv | 33 +++
 rtl/mlblock_seq_cnt.sv | 28 ++
 rtl/mlblock_tile_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mlblock_tile_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mlblock_seq_pkg.sv
// Shared types for the MLBlock_2Dflex tile sequencer: FSM states, the start
// command bundle and the effective per-pass compute length.
package mlblock_seq_pkg;

  localparam int SEQ_CFG_LEN   = 16;
  localparam int SEQ_CNT_W     = 16;
  localparam int SEQ_CFG_SEL_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_WLOAD = 3'd2,
    S_COMP  = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5
  } seq_state_t;

  // Field widths follow the default sequencer parameters.
  typedef struct packed {
    logic [SEQ_CFG_LEN-1:0]   cfg_word;
    logic [SEQ_CFG_SEL_W-1:0] cfg_sel;
    logic [SEQ_CNT_W-1:0]     w_cycles;
    logic [SEQ_CNT_W-1:0]     k_cycles;
    logic [SEQ_CNT_W-1:0]     n_passes;
    logic                     cfg_skip;
  } seq_cmd_t;

  // A zero k count still runs one compute cycle per pass.
  function automatic logic [SEQ_CNT_W-1:0] k_eff(input logic [SEQ_CNT_W-1:0] k);
    return (k == '0) ? SEQ_CNT_W'(1) : k;
  endfunction

endpackage

// File: rtl/mlblock_seq_cnt.sv
// Loadable down-counter shared by all timed sequencer phases; zero marks the
// last cycle of the current phase.
module mlblock_seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mlblock_tile_sequencer.sv
// Sequences one MLBlock_2Dflex tile: config chain shift, weight load, then
// accumulation passes (compute + drain). All block-side outputs are registered.
module mlblock_tile_sequencer
  import mlblock_seq_pkg::*;
#(
  parameter int CFG_LEN   = SEQ_CFG_LEN,
  parameter int CNT_W     = SEQ_CNT_W,
  parameter int DRAIN_CYC = 3,
  parameter int CFG_SEL_W = SEQ_CFG_SEL_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_skip,
  input  logic [CFG_LEN-1:0]   cfg_word,
  input  logic [CFG_SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0]     w_cycles,
  input  logic [CNT_W-1:0]     k_cycles,
  input  logic [CNT_W-1:0]     n_passes,
  output logic [CFG_SEL_W-1:0] configg,
  output logic                 config_en,
  output logic                 config_in,
  output logic                 W_en,
  output logic                 I_en,
  output logic                 Res_en,
  output logic                 Res_cas_in_zero,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_t         state, nxt;
  seq_cmd_t           cmd_in;
  logic [CFG_LEN-1:0] cfg_sr;
  logic [CNT_W-1:0]   w_q, k_q, pass_q;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic               accept;

  assign cmd_in = '{cfg_word: cfg_word, cfg_sel: cfg_sel, w_cycles: w_cycles,
                    k_cycles: k_cycles, n_passes: n_passes, cfg_skip: cfg_skip};
  assign accept    = (state == S_IDLE) && start && !abort;
  assign state_dbg = state;

  mlblock_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Counter holds (remaining cycles - 1); zero-length phases are never entered.
  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          if (!cmd_in.cfg_skip) begin
            nxt     = S_CFG;
            cnt_val = CNT_W'(CFG_LEN - 1);
          end else if (cmd_in.w_cycles != '0) begin
            nxt     = S_WLOAD;
            cnt_val = cmd_in.w_cycles - CNT_ONE;
          end else if (cmd_in.n_passes != '0) begin
            nxt     = S_COMP;
            cnt_val = k_eff(cmd_in.k_cycles) - CNT_ONE;
          end else begin
            nxt      = S_FIN;
            cnt_load = 1'b0;
          end
        end
      end
      S_CFG: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (w_q != '0) begin
          nxt      = S_WLOAD;
          cnt_load = 1'b1;
          cnt_val  = w_q - CNT_ONE;
        end else if (pass_q != '0) begin
          nxt      = S_COMP;
          cnt_load = 1'b1;
          cnt_val  = k_q - CNT_ONE;
        end else begin
          nxt = S_FIN;
        end
      end
      S_WLOAD: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (pass_q != '0) begin
          nxt      = S_COMP;
          cnt_load = 1'b1;
          cnt_val  = k_q - CNT_ONE;
        end else begin
          nxt = S_FIN;
        end
      end
      S_COMP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          nxt      = S_DRAIN;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (pass_q != CNT_ONE) begin
          nxt      = S_COMP;
          cnt_load = 1'b1;
          cnt_val  = k_q - CNT_ONE;
        end else begin
          nxt = S_FIN;
        end
      end
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) begin
      nxt      = S_IDLE;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      configg         <= '0;
      config_en       <= 1'b0;
      config_in       <= 1'b0;
      W_en            <= 1'b0;
      I_en            <= 1'b0;
      Res_en          <= 1'b0;
      Res_cas_in_zero <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_sr          <= '0;
      w_q             <= '0;
      k_q             <= '0;
      pass_q          <= '0;
    end else begin
      state           <= nxt;
      config_en       <= (nxt == S_CFG);
      config_in       <= (nxt == S_CFG) &&
                         (accept ? cmd_in.cfg_word[CFG_LEN-1] : cfg_sr[CFG_LEN-1]);
      W_en            <= (nxt == S_WLOAD);
      I_en            <= (nxt == S_COMP);
      Res_en          <= (nxt == S_COMP) || (nxt == S_DRAIN);
      Res_cas_in_zero <= (nxt == S_COMP) && (state != S_COMP);
      busy            <= (nxt != S_IDLE);
      done            <= (nxt == S_FIN);
      if (accept) begin
        configg <= cmd_in.cfg_sel;
        cfg_sr  <= cmd_in.cfg_word << 1;
        w_q     <= cmd_in.w_cycles;
        k_q     <= k_eff(cmd_in.k_cycles);
        pass_q  <= cmd_in.n_passes;
      end else if (state == S_CFG) begin
        cfg_sr <= cfg_sr << 1;
      end
      if ((state == S_DRAIN) && cnt_zero && !abort) begin
        pass_q <= pass_q - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mlblock_tile_sequencer.sv
// Directed bench for mlblock_tile_sequencer: per-cycle output vectors are
// queued from hand-derived phase lengths and compared on the falling edge.
module tb_mlblock_tile_sequencer;

  // Vector layout: {config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero, busy, done}
  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_CFG0 = 8'b1000_0010;
  localparam logic [7:0] V_CFG1 = 8'b1100_0010;
  localparam logic [7:0] V_W    = 8'b0010_0010;
  localparam logic [7:0] V_CF   = 8'b0001_1110;
  localparam logic [7:0] V_C    = 8'b0001_1010;
  localparam logic [7:0] V_D    = 8'b0000_1010;
  localparam logic [7:0] V_FIN  = 8'b0000_0011;

  logic        clk;
  logic        reset, start, abort, cfg_skip;
  logic [15:0] cfg_word, w_cycles, k_cycles, n_passes;
  logic [1:0]  cfg_sel, configg;
  logic        config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero, busy, done;
  logic [2:0]  state_dbg;
  logic [7:0]  obs;

  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  mlblock_tile_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_skip        (cfg_skip),
    .cfg_word        (cfg_word),
    .cfg_sel         (cfg_sel),
    .w_cycles        (w_cycles),
    .k_cycles        (k_cycles),
    .n_passes        (n_passes),
    .configg         (configg),
    .config_en       (config_en),
    .config_in       (config_in),
    .W_en            (W_en),
    .I_en            (I_en),
    .Res_en          (Res_en),
    .Res_cas_in_zero (Res_cas_in_zero),
    .busy            (busy),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  assign obs = {config_en, config_in, W_en, I_en, Res_en, Res_cas_in_zero, busy, done};

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver and scoreboard tasks
  task automatic check_now(input string tag, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_sel(input string tag, input logic [1:0] exp_v);
    checks++;
    assert (configg === exp_v) else begin
      errors++;
      $error("FAIL %s configg observed=%0d expected=%0d", tag, configg, exp_v);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp_v);
    checks++;
    assert (state_dbg === exp_v) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, exp_v);
    end
  endtask

  task automatic check_one(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check_now(tag, e);
    @(negedge clk);
  endtask

  task automatic check_queue(input string tag);
    while (exp_q.size() > 0) check_one(tag);
  endtask

  task automatic push_n(input logic [7:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic push_bits(input logic [15:0] bits, input int n);
    for (int i = 15; i > 15 - n; i--) exp_q.push_back(bits[i] ? V_CFG1 : V_CFG0);
  endtask

  task automatic push_pass(input int k);
    push_n(V_CF, 1);
    push_n(V_C, k - 1);
    push_n(V_D, 3);
  endtask

  task automatic issue(input logic skip, input logic [15:0] word, input logic [1:0] sel,
                       input logic [15:0] w, input logic [15:0] k, input logic [15:0] n);
    cfg_skip = skip;
    cfg_word = word;
    cfg_sel  = sel;
    w_cycles = w;
    k_cycles = k;
    n_passes = n;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_full_cmd();
    push_bits(16'b1010_0101_1100_0011, 16);
    push_n(V_W, 4);
    push_pass(8);
    push_pass(8);
    push_n(V_FIN, 1);
    push_n(V_IDLE, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_skip = 1'b0;
    cfg_word = 16'h0; cfg_sel = 2'd0; w_cycles = 16'd0; k_cycles = 16'd0; n_passes = 16'd0;
    repeat (3) @(negedge clk);
    check_now("reset_outputs", V_IDLE);
    check_sel("reset_configg", 2'd0);
    check_state("reset_state", 3'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full command: 16 config bits, 4 weight cycles, 2 passes of 8+3, done at 43
    push_full_cmd();
    issue(1'b0, 16'hA5C3, 2'd1, 16'd4, 16'd8, 16'd2);
    check_queue("full_seq");
    check_sel("full_configg", 2'd1);

    // Skip config, no weights, k=0 -> one compute cycle per pass
    push_pass(1);
    push_n(V_FIN, 1);
    push_n(V_IDLE, 1);
    issue(1'b1, 16'hFFFF, 2'd2, 16'd0, 16'd0, 16'd1);
    check_queue("k_zero");
    check_sel("k_zero_configg", 2'd2);

    // Zero passes -> done on the first busy cycle, then back-to-back start
    push_n(V_FIN, 1);
    issue(1'b1, 16'h0000, 2'd3, 16'd0, 16'd5, 16'd0);
    check_queue("n_zero");
    check_now("n_zero_idle_gap", V_IDLE);
    push_n(V_FIN, 1);
    push_n(V_IDLE, 1);
    issue(1'b1, 16'h0000, 2'd0, 16'd0, 16'd0, 16'd0);
    check_queue("back_to_back");
    check_sel("back_to_back_configg", 2'd0);

    // Abort on the third compute cycle
    push_n(V_W, 2);
    push_n(V_CF, 1);
    push_n(V_C, 1);
    issue(1'b1, 16'h0000, 2'd2, 16'd2, 16'd8, 16'd1);
    check_queue("pre_abort");
    check_now("abort_comp3", V_C);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_now("abort_next", V_IDLE);
    check_sel("abort_configg_held", 2'd2);
    @(negedge clk);
    check_now("abort_stays_idle", V_IDLE);
    push_full_cmd();
    issue(1'b0, 16'hA5C3, 2'd1, 16'd4, 16'd8, 16'd2);
    check_queue("after_abort");

    // start during WLOAD with different counts is ignored
    push_n(V_W, 4);
    push_pass(2);
    push_n(V_FIN, 1);
    push_n(V_IDLE, 1);
    issue(1'b1, 16'h0000, 2'd1, 16'd4, 16'd2, 16'd1);
    check_one("ignore_start");
    cfg_skip = 1'b0; cfg_word = 16'hFFFF; cfg_sel = 2'd3;
    w_cycles = 16'd9; k_cycles = 16'd5; n_passes = 16'd3; start = 1'b1;
    check_one("ignore_start");
    start = 1'b0;
    check_queue("ignore_start");
    check_sel("ignore_start_configg", 2'd1);

    // reset together with abort in the middle of the config shift
    push_bits(16'b1010_0101_1100_0011, 3);
    issue(1'b0, 16'hA5C3, 2'd3, 16'd4, 16'd8, 16'd2);
    check_queue("pre_reset");
    check_now("pre_reset_bit4", V_CFG0);
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    check_now("mid_reset_outputs", V_IDLE);
    check_sel("mid_reset_configg", 2'd0);
    check_state("mid_reset_state", 3'd0);
    @(negedge clk);
    check_now("post_reset_idle", V_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
